// File: rtl/rename_ckpt_ctrl.sv
// Rename-stage checkpoint controller.
// Grants physical-register allocations from the free list. Takes branch
// checkpoints of the free-list read pointer in a circular buffer. On a branch
// mispredict it drives a one-cycle restore pulse back to the free list.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   alloc_req, fl_empty    allocation request / free list empty
//   fl_r_ptr               current free-list read pointer
//   alloc_grant            free-list read enable
//   br_dispatch            branch at rename wants a checkpoint
//   ckpt_grant, br_tag     checkpoint taken / tag assigned to the branch
//   br_resolve, br_resolve_tag, br_mispredict   branch resolution
//   fl_mispredict, fl_re_r_ptr                  restore pulse / restore pointer
//   stall                  rename must hold this cycle
//   ckpt_count             occupied checkpoint slots
module rename_ckpt_ctrl #(
    parameter int DEPTH = 96,
    parameter int NCKPT = 4,
    parameter int PW    = 7,
    parameter int TW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alloc_req,
    input  logic          fl_empty,
    input  logic [PW-1:0] fl_r_ptr,
    output logic          alloc_grant,
    input  logic          br_dispatch,
    output logic          ckpt_grant,
    output logic [TW-1:0] br_tag,
    input  logic          br_resolve,
    input  logic [TW-1:0] br_resolve_tag,
    input  logic          br_mispredict,
    output logic          fl_mispredict,
    output logic [PW-1:0] fl_re_r_ptr,
    output logic          stall,
    output logic [TW:0]   ckpt_count
);

    typedef enum logic {IDLE, RECOVER} state_t;

    state_t           state_q, state_d;
    logic [NCKPT-1:0] valid_q;
    logic [PW-1:0]    rptr_q [NCKPT];
    logic [TW-1:0]    head_q, tail_q;
    logic [TW:0]      count_q;
    logic [PW-1:0]    re_ptr_q;

    logic             idle;
    logic             mp_any, mp_take, res_ok, head_adv;
    logic [NCKPT-1:0] valid_eff, clear_mask;
    logic [PW-1:0]    new_rptr;
    logic [TW-1:0]    d_t;

    always_comb begin
        idle        = (state_q == IDLE);
        mp_any      = br_resolve & br_mispredict;
        mp_take     = idle & mp_any & valid_q[br_resolve_tag];
        res_ok      = br_resolve & ~br_mispredict & valid_q[br_resolve_tag];
        alloc_grant = ~reset & idle & alloc_req & ~fl_empty;
        ckpt_grant  = ~reset & idle & br_dispatch &
                      (count_q < (TW+1)'(NCKPT)) & ~mp_any;
        stall       = ~reset & (~idle | (br_dispatch & ~ckpt_grant) |
                                (alloc_req & fl_empty));
        fl_mispredict = (state_q == RECOVER);
        fl_re_r_ptr   = re_ptr_q;
        br_tag        = tail_q;
        ckpt_count    = count_q;

        // The branch is younger than a same-cycle allocation, so its
        // checkpoint points past the register being granted now.
        if (alloc_grant && (fl_r_ptr == PW'(DEPTH-1)))
            new_rptr = '0;
        else
            new_rptr = fl_r_ptr + PW'(alloc_grant);

        // A correct resolve landing on the head this cycle retires it now,
        // so the slot frees up on the very next cycle.
        valid_eff = valid_q;
        if (res_ok)
            valid_eff[br_resolve_tag] = 1'b0;
        head_adv = (count_q != '0) & ~valid_eff[head_q] & ~mp_take;

        // Age is measured from head: the mispredicted tag and everything
        // younger than it gets invalidated.
        d_t        = br_resolve_tag - head_q;
        clear_mask = '0;
        for (int unsigned i = 0; i < NCKPT; i++)
            clear_mask[i] = ((TW'(i) - head_q) >= d_t);

        state_d = mp_take ? RECOVER : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            re_ptr_q <= '0;
            for (int unsigned i = 0; i < NCKPT; i++)
                rptr_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (mp_take) begin
                re_ptr_q <= rptr_q[br_resolve_tag];
                tail_q   <= br_resolve_tag + TW'(1);
                count_q  <= (TW+1)'({1'b0, d_t}) + (TW+1)'(1);
                valid_q  <= valid_q & ~clear_mask;
            end else begin
                if (ckpt_grant) begin
                    valid_q         <= valid_eff | (NCKPT'(1) << tail_q);
                    rptr_q[tail_q]  <= new_rptr;
                    tail_q          <= tail_q + TW'(1);
                end else begin
                    valid_q <= valid_eff;
                end
                if (head_adv)
                    head_q <= head_q + TW'(1);
                count_q <= count_q + (TW+1)'(ckpt_grant) - (TW+1)'(head_adv);
            end
        end
    end

endmodule

// File: tb/tb_rename_ckpt_ctrl.sv
// Scoreboard bench for rename_ckpt_ctrl: each directed stimulus cycle queues
// its hand-computed expected outputs; a monitor compares them on the falling edge.
module tb_rename_ckpt_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alloc_req = 1'b0, fl_empty = 1'b0;
    logic [6:0] fl_r_ptr = '0;
    logic       alloc_grant;
    logic       br_dispatch = 1'b0;
    logic       ckpt_grant;
    logic [1:0] br_tag;
    logic       br_resolve = 1'b0;
    logic [1:0] br_resolve_tag = '0;
    logic       br_mispredict = 1'b0;
    logic       fl_mispredict;
    logic [6:0] fl_re_r_ptr;
    logic       stall;
    logic [2:0] ckpt_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        logic       ag, cg;
        logic [1:0] tag;
        logic       fm;
        logic [6:0] rr;
        logic       st;
        logic [2:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rename_ckpt_ctrl #(.DEPTH(96), .NCKPT(4), .PW(7), .TW(2)) dut (
        .clk(clk), .reset(reset),
        .alloc_req(alloc_req), .fl_empty(fl_empty), .fl_r_ptr(fl_r_ptr),
        .alloc_grant(alloc_grant),
        .br_dispatch(br_dispatch), .ckpt_grant(ckpt_grant), .br_tag(br_tag),
        .br_resolve(br_resolve), .br_resolve_tag(br_resolve_tag),
        .br_mispredict(br_mispredict),
        .fl_mispredict(fl_mispredict), .fl_re_r_ptr(fl_re_r_ptr),
        .stall(stall), .ckpt_count(ckpt_count)
    );

    task automatic chk(input string nm, input string fld,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %0d expected %0d", nm, fld, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.nm, "alloc_grant",   8'(alloc_grant),   8'(e.ag));
                chk(e.nm, "ckpt_grant",    8'(ckpt_grant),    8'(e.cg));
                chk(e.nm, "br_tag",        8'(br_tag),        8'(e.tag));
                chk(e.nm, "fl_mispredict", 8'(fl_mispredict), 8'(e.fm));
                chk(e.nm, "fl_re_r_ptr",   8'(fl_re_r_ptr),   8'(e.rr));
                chk(e.nm, "stall",         8'(stall),         8'(e.st));
                chk(e.nm, "ckpt_count",    8'(ckpt_count),    8'(e.cnt));
            end
        end
    end

    task automatic step(input string nm, input logic rst,
                        input logic ar, input logic fe, input logic [6:0] rp,
                        input logic bd, input logic rs, input logic [1:0] rt,
                        input logic mp,
                        input logic e_ag, input logic e_cg, input logic [1:0] e_tag,
                        input logic e_fm, input logic [6:0] e_rr,
                        input logic e_st, input logic [2:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; alloc_req = ar; fl_empty = fe; fl_r_ptr = rp;
        br_dispatch = bd; br_resolve = rs; br_resolve_tag = rt; br_mispredict = mp;
        e.nm = nm; e.ag = e_ag; e.cg = e_cg; e.tag = e_tag; e.fm = e_fm;
        e.rr = e_rr; e.st = e_st; e.cnt = e_cnt;
        sb.push_back(e);
    endtask

    initial begin
        //        name     rst ar fe rp  bd rs rt mp   ag cg tag fm rr  st cnt
        step("rst0",      1, 1, 0, 10, 1, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0);
        step("alloc10",   0, 1, 0, 10, 1, 0, 0, 0,   1, 1, 0, 0, 0,  0, 0);
        step("idle1",     0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 1, 0, 0,  0, 1);
        step("wrap95",    0, 1, 0, 95, 1, 0, 0, 0,   1, 1, 1, 0, 0,  0, 1);
        step("disp2",     0, 0, 0, 20, 1, 0, 0, 0,   0, 1, 2, 0, 0,  0, 2);
        step("disp3",     0, 0, 0, 30, 1, 0, 0, 0,   0, 1, 3, 0, 0,  0, 3);
        step("full5th",   0, 0, 0, 33, 1, 0, 0, 0,   0, 0, 0, 0, 0,  1, 4);
        step("res0",      0, 0, 0, 0,  0, 1, 0, 0,   0, 0, 0, 0, 0,  0, 4);
        step("cnt3",      0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 3);
        step("mp1alloc",  0, 1, 0, 12, 0, 1, 1, 1,   1, 0, 0, 0, 0,  0, 3);
        step("recWrap",   0, 1, 0, 12, 1, 1, 2, 1,   0, 0, 2, 1, 0,  1, 1);
        step("idleW",     0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 2, 0, 0,  0, 0);
        step("rst1",      1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0);
        step("t0",        0, 0, 0, 5,  1, 0, 0, 0,   0, 1, 0, 0, 0,  0, 0);
        step("t1",        0, 0, 0, 40, 1, 0, 0, 0,   0, 1, 1, 0, 0,  0, 1);
        step("t2empty",   0, 1, 1, 50, 1, 0, 0, 0,   0, 1, 2, 0, 0,  1, 2);
        step("mp1",       0, 0, 0, 0,  0, 1, 1, 1,   0, 0, 3, 0, 0,  0, 3);
        step("rec40",     0, 1, 0, 0,  0, 1, 0, 1,   0, 0, 2, 1, 40, 1, 2);
        step("back40",    0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 2, 0, 40, 0, 2);
        step("mp0disp",   0, 0, 0, 9,  1, 1, 0, 1,   0, 0, 2, 0, 40, 1, 2);
        step("rec5",      0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 1, 1, 5,  1, 1);
        step("back5",     0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 1, 0, 5,  0, 0);
        step("disp60",    0, 0, 0, 60, 1, 0, 0, 0,   0, 1, 1, 0, 5,  0, 0);
        step("mp60",      0, 0, 0, 0,  0, 1, 1, 1,   0, 0, 2, 0, 5,  0, 1);
        step("rstRec",    1, 1, 0, 3,  1, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0);
        step("postRst",   0, 0, 0, 7,  1, 0, 0, 0,   0, 1, 0, 0, 0,  0, 0);
        @(posedge clk);
        #1;
        br_dispatch = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_ckpt_ctrl.md
RENAME_CKPT_CTRL -- requirements
Module: rename_ckpt_ctrl

Interface
REQ-001 SHALL have parameters: DEPTH 96 free-list entries; NCKPT 4 branch checkpoints; PW 7 pointer width; TW 2 tag width (log2 NCKPT).
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port reset, input, 1: asynchronous active-high reset.
REQ-005 Port alloc_req, input, 1: rename stage requests one physical register.
REQ-006 Port fl_empty, input, 1: free list has no free entry.
REQ-007 Port fl_r_ptr, input, PW: current free-list read pointer.
REQ-008 Port alloc_grant, output, 1: drives free-list read_en.
REQ-009 Port br_dispatch, input, 1: branch at rename requests a checkpoint.
REQ-010 Port ckpt_grant, output, 1: checkpoint taken this cycle.
REQ-011 Port br_tag, output, TW: tag assigned to the branch; valid when ckpt_grant=1.
REQ-012 Port br_resolve, input, 1: branch resolved this cycle.
REQ-013 Port br_resolve_tag, input, TW: tag of the resolving branch.
REQ-014 Port br_mispredict, input, 1: qualifies br_resolve; 1 = mispredicted.
REQ-015 Port fl_mispredict, output, 1: restore pulse to the free list.
REQ-016 Port fl_re_r_ptr, output, PW: read pointer to restore.
REQ-017 Port stall, output, 1: rename must hold this cycle.
REQ-018 Port ckpt_count, output, TW+1: occupied checkpoint slots.

Function
REQ-019 SHALL keep NCKPT entries {valid, rptr} in a circular buffer with head (oldest), tail (next free) and count, all wrapping modulo NCKPT.
REQ-020 SHALL run FSM IDLE/RECOVER; RECOVER lasts exactly one cycle and then returns to IDLE.
REQ-021 In IDLE, alloc_grant = alloc_req & ~fl_empty; in RECOVER, alloc_grant = 0.
REQ-022 In IDLE, ckpt_grant = br_dispatch & (count < NCKPT) & ~(br_resolve & br_mispredict).
REQ-023 On ckpt_grant, SHALL write entry[tail] = {1, fl_r_ptr + alloc_grant}, wrapping DEPTH-1 -> 0; a same-cycle allocation is older than the branch. br_tag = tail; tail advances.
REQ-024 A correct resolve (br_resolve & ~br_mispredict) of a valid tag SHALL clear that entry's valid bit; resolving an invalid tag SHALL be ignored.
REQ-025 Head SHALL advance past at most one invalid entry per cycle while count > 0; count = occupied slots from head to tail.
REQ-026 A mispredict of a valid tag t in IDLE SHALL register fl_re_r_ptr = entry[t].rptr, set tail = t+1, clear valid for all entries younger than t, clear t, recompute count, and enter RECOVER.
REQ-027 fl_mispredict SHALL be 1 exactly during the RECOVER cycle.
REQ-028 A mispredict of an invalid tag, or any mispredict during RECOVER, SHALL be ignored.
REQ-029 stall = (state==RECOVER) | (br_dispatch & ~ckpt_grant) | (alloc_req & fl_empty).
REQ-030 Same-cycle correct resolve and dispatch SHALL both take effect.
REQ-031 Same-cycle mispredict and dispatch: the mispredict wins; the dispatch is dropped and stalled.

Reset
REQ-032 Asserting reset SHALL immediately force IDLE, head = tail = count = 0, all valid bits = 0, alloc_grant = ckpt_grant = fl_mispredict = 0, fl_re_r_ptr = 0, br_tag = 0, stall = 0.
REQ-033 Reset asserted during RECOVER SHALL abort the restore without emitting fl_mispredict.

Verification
REQ-034 Test: fl_r_ptr=10, alloc_req=1, br_dispatch=1 -> ckpt_grant=1, br_tag=0, entry0.rptr=11.
REQ-035 Test: fl_r_ptr=95, alloc_req=1, br_dispatch=1 -> stored rptr=0 (wrap).
REQ-036 Test: 4 dispatches, then a 5th -> ckpt_grant=0, stall=1, ckpt_count=4; correct resolve of tag0 -> count=3 next cycle.
REQ-037 Test: tags 0,1,2 live; mispredict tag1 with rptr=40 -> next cycle fl_mispredict=1, fl_re_r_ptr=40, alloc_grant=0, tags1-2 invalid, tail=2; the cycle after -> IDLE.
REQ-038 Test: same-cycle mispredict tag0 and br_dispatch -> ckpt_grant=0, stall=1; a mispredict during RECOVER is ignored.
REQ-039 Test: reset during RECOVER -> fl_mispredict=0 and ckpt_count=0 immediately.
